// File: rtl/vending_machine_pkg.sv
// Shared types and default sizing for the vending machine core and its helpers.
package vending_machine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RETURN = 2'd2
    } vm_state_t;

    localparam int DEF_NUM_COINS   = 3;
    localparam int DEF_NUM_ITEMS   = 4;
    localparam int DEF_TOTAL_BITS  = 31;
    localparam int DEF_WAIT_CYCLES = 100;
    localparam int DEF_STOCK_BITS  = 4;
    localparam int DEF_INIT_STOCK  = 8;

endpackage

// File: rtl/vm_change_select.sv
// Picks the largest coin denomination that still fits in the remaining credit.
module vm_change_select
    import vending_machine_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int TOTAL_BITS = DEF_TOTAL_BITS
) (
    input  logic [TOTAL_BITS-1:0]           remaining,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
    output logic [NUM_COINS-1:0]            coin_onehot,
    output logic [TOTAL_BITS-1:0]           coin_amount
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        coin_onehot = '0;
        coin_amount = '0;
        // Denominations ascend with index, so the last one that fits is the largest.
        for (int j = 0; j < NUM_COINS; j++) begin
            if ((coin_value[j*TOTAL_BITS +: TOTAL_BITS] != '0) &&
                (coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= remaining)) begin
                coin_onehot    = '0;
                coin_onehot[j] = 1'b1;
                coin_amount    = coin_value[j*TOTAL_BITS +: TOTAL_BITS];
            end
        end
    end

endmodule

// File: rtl/vending_machine_core.sv
// Vending machine controller: credit accumulation, item dispense with stock
// tracking, inactivity timeout and coin-by-coin change return.
module vending_machine_core
    import vending_machine_pkg::*;
#(
    parameter int NUM_COINS   = DEF_NUM_COINS,
    parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int STOCK_BITS  = DEF_STOCK_BITS,
    parameter int INIT_STOCK  = DEF_INIT_STOCK
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS-1:0]            i_input_coin,
    input  logic [NUM_ITEMS-1:0]            i_select_item,
    input  logic                            i_trigger_return,
    input  logic                            i_restock,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
    input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
    output logic [NUM_ITEMS-1:0]            o_available_item,
    output logic [NUM_ITEMS-1:0]            o_output_item,
    output logic [NUM_COINS-1:0]            o_return_coin,
    output logic                            o_coin_reject,
    output logic [TOTAL_BITS-1:0]           o_current_total,
    output logic                            o_busy
);

    localparam int TIMER_BITS = $clog2(WAIT_CYCLES + 1);
    localparam int SUM_BITS   = TOTAL_BITS + $clog2(NUM_COINS + 1) + 1;
    localparam logic [TIMER_BITS-1:0] WAIT_LOAD  = TIMER_BITS'(WAIT_CYCLES);
    localparam logic [STOCK_BITS-1:0] STOCK_LOAD = STOCK_BITS'(INIT_STOCK);
    localparam logic [SUM_BITS-1:0]   TOTAL_MAX  = SUM_BITS'({TOTAL_BITS{1'b1}});

    vm_state_t             state_q;
    logic [TOTAL_BITS-1:0] total_q;
    logic [TIMER_BITS-1:0] timer_q;
    logic [STOCK_BITS-1:0] stock_q [NUM_ITEMS];

    logic [TOTAL_BITS-1:0] price [NUM_ITEMS];
    logic [SUM_BITS-1:0]   coin_sum;
    logic                  coin_any;
    logic                  coin_overflow;
    logic                  coin_accept;
    logic [NUM_ITEMS-1:0]  disp_onehot;
    logic [TOTAL_BITS-1:0] disp_price;
    logic                  disp_any;
    logic [TOTAL_BITS-1:0] accept_total;
    logic [NUM_COINS-1:0]  change_onehot;
    logic [TOTAL_BITS-1:0] change_amount;

    always_comb begin
        coin_sum = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (i_input_coin[j]) begin
                coin_sum = coin_sum + SUM_BITS'(i_coin_value[j*TOTAL_BITS +: TOTAL_BITS]);
            end
        end
    end

    assign coin_any      = |i_input_coin;
    assign coin_overflow = (SUM_BITS'(total_q) + coin_sum) > TOTAL_MAX;
    assign coin_accept   = coin_any && !coin_overflow &&
                           (((state_q == ST_IDLE) && !i_restock) || (state_q == ST_ACCEPT));

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price[i]            = i_item_price[i*TOTAL_BITS +: TOTAL_BITS];
            o_available_item[i] = (state_q == ST_ACCEPT) && (stock_q[i] != '0) &&
                                  (total_q >= price[i]);
        end
    end

    // Walk from the top index down so the lowest eligible selection wins.
    always_comb begin
        disp_onehot = '0;
        disp_price  = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (i_select_item[i] && o_available_item[i]) begin
                disp_onehot    = '0;
                disp_onehot[i] = 1'b1;
                disp_price     = price[i];
            end
        end
    end

    assign disp_any     = |disp_onehot;
    assign accept_total = total_q - disp_price +
                          (coin_accept ? coin_sum[TOTAL_BITS-1:0] : '0);

    vm_change_select #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_change_select (
        .remaining   (total_q),
        .coin_value  (i_coin_value),
        .coin_onehot (change_onehot),
        .coin_amount (change_amount)
    );

    assign o_current_total = total_q;

    // NOTE: state is updated with non-blocking assignments only, so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            total_q       <= '0;
            timer_q       <= '0;
            // NOTE: the stock array is a handful of flops, not a RAM, so it takes a reset value.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_LOAD;
            end
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_output_item <= '0;
            o_return_coin <= '0;
            o_coin_reject <= coin_any && !coin_accept;

            case (state_q)
                ST_IDLE: begin
                    total_q <= '0;
                    timer_q <= '0;
                    if (i_restock) begin
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            stock_q[i] <= STOCK_LOAD;
                        end
                    end
                    if (coin_accept) begin
                        total_q <= coin_sum[TOTAL_BITS-1:0];
                        timer_q <= WAIT_LOAD;
                        state_q <= ST_ACCEPT;
                    end
                end

                ST_ACCEPT: begin
                    total_q <= accept_total;
                    if (disp_any) begin
                        o_output_item <= disp_onehot;
                        for (int i = 0; i < NUM_ITEMS; i++) begin
                            if (disp_onehot[i] && (stock_q[i] != '0)) begin
                                stock_q[i] <= stock_q[i] - 1'b1;
                            end
                        end
                    end
                    if (coin_accept || disp_any) begin
                        timer_q <= WAIT_LOAD;
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end
                    // Timeout fires on the edge where the idle countdown hits zero.
                    if (i_trigger_return ||
                        (!coin_accept && !disp_any && (timer_q <= 1))) begin
                        timer_q <= '0;
                        state_q <= ST_RETURN;
                        o_busy  <= 1'b1;
                    end
                end

                ST_RETURN: begin
                    if ((total_q == '0) || (change_onehot == '0)) begin
                        total_q <= '0;
                        state_q <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        o_return_coin <= change_onehot;
                        total_q       <= total_q - change_amount;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed self-checking bench for vending_machine_core (coins 100/500/1000,
// prices 400/500/1000/2000, 10-cycle inactivity timeout).
module tb_vending_machine_core;

    localparam int NC = 3;
    localparam int NI = 4;
    localparam int TB = 31;

    logic              clk;
    logic              reset_n;
    logic [NC-1:0]     input_coin;
    logic [NI-1:0]     select_item;
    logic              trigger_return;
    logic              restock;
    logic [NC*TB-1:0]  coin_value;
    logic [NI*TB-1:0]  item_price;
    logic [NI-1:0]     available_item;
    logic [NI-1:0]     output_item;
    logic [NC-1:0]     return_coin;
    logic              coin_reject;
    logic [TB-1:0]     current_total;
    logic              busy;

    int errors = 0;
    int checks = 0;

    vending_machine_core #(
        .NUM_COINS   (NC),
        .NUM_ITEMS   (NI),
        .TOTAL_BITS  (TB),
        .WAIT_CYCLES (10),
        .STOCK_BITS  (4),
        .INIT_STOCK  (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (input_coin),
        .i_select_item    (select_item),
        .i_trigger_return (trigger_return),
        .i_restock        (restock),
        .i_coin_value     (coin_value),
        .i_item_price     (item_price),
        .o_available_item (available_item),
        .o_output_item    (output_item),
        .o_return_coin    (return_coin),
        .o_coin_reject    (coin_reject),
        .o_current_total  (current_total),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        input_coin     = '0;
        select_item    = '0;
        trigger_return = 1'b0;
        restock        = 1'b0;
    endtask

    // Runs change return to completion under a cycle bound and counts pulses.
    task automatic drain(input string tag, input int exp_pulses);
        int pulses = 0;
        bit done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (return_coin != '0) pulses++;
            if (!busy) done = 1'b1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        check({tag, "_total"}, 64'(current_total), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clear_inputs();
        coin_value = {31'd1000, 31'd500, 31'd100};
        item_price = {31'd2000, 31'd1000, 31'd500, 31'd400};
        reset_n    = 1'b0;
        #23;
        check("rst_total", 64'(current_total), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_avail", 64'(available_item), 64'd0);
        check("rst_out", 64'(output_item), 64'd0);
        check("rst_ret", 64'(return_coin), 64'd0);
        check("rst_rej", 64'(coin_reject), 64'd0);
        reset_n = 1'b1;
        tick();

        // Insert 1000, buy item0.
        input_coin = 3'b100; tick(); clear_inputs();
        check("t1_total", 64'(current_total), 64'd1000);
        check("t1_avail", 64'(available_item), 64'b0111);
        select_item = 4'b0001; tick(); clear_inputs();
        check("t1_out", 64'(output_item), 64'b0001);
        check("t1_total_after", 64'(current_total), 64'd600);
        check("t1_stock0", 64'(dut.stock_q[0]), 64'd7);
        check("t1_avail_after", 64'(available_item), 64'b0011);
        tick();
        check("t1_out_pulse", 64'(output_item), 64'd0);

        // Return 600 as 500 then 100.
        trigger_return = 1'b1; tick(); clear_inputs();
        check("r600_busy", 64'(busy), 64'd1);
        tick();
        check("r600_c1", 64'(return_coin), 64'b010);
        tick();
        check("r600_c2", 64'(return_coin), 64'b001);
        tick();
        check("r600_idle", 64'(busy), 64'd0);

        // 500+100 in one cycle, select items1 and 0: only item0 goes.
        input_coin = 3'b011; tick(); clear_inputs();
        check("t2_total", 64'(current_total), 64'd600);
        check("t2_rej", 64'(coin_reject), 64'd0);
        select_item = 4'b0011; tick(); clear_inputs();
        check("t2_out", 64'(output_item), 64'b0001);
        check("t2_total_after", 64'(current_total), 64'd200);
        check("t2_avail", 64'(available_item), 64'b0000);
        trigger_return = 1'b1; tick(); clear_inputs();
        drain("r200", 2);

        // 1600 returned as 1000, 500, 100 on consecutive cycles.
        input_coin = 3'b111; tick(); clear_inputs();
        check("t3_total", 64'(current_total), 64'd1600);
        trigger_return = 1'b1; tick(); clear_inputs();
        check("t3_busy", 64'(busy), 64'd1);
        tick();
        check("t3_c1000", 64'(return_coin), 64'b100);
        check("t3_rem1", 64'(current_total), 64'd600);
        tick();
        check("t3_c500", 64'(return_coin), 64'b010);
        tick();
        check("t3_c100", 64'(return_coin), 64'b001);
        check("t3_busy_mid", 64'(busy), 64'd1);
        tick();
        check("t3_ret_end", 64'(return_coin), 64'd0);
        check("t3_busy_end", 64'(busy), 64'd0);

        // 500 left untouched for 10 cycles times out; coin during RETURN refused.
        input_coin = 3'b010; tick(); clear_inputs();
        for (int i = 0; i < 9; i++) tick();
        check("t4_wait_busy", 64'(busy), 64'd0);
        check("t4_wait_total", 64'(current_total), 64'd500);
        tick();
        check("t4_timeout", 64'(busy), 64'd1);
        check("t4_no_pulse_yet", 64'(return_coin), 64'd0);
        input_coin = 3'b001; tick(); clear_inputs();
        check("t4_c500", 64'(return_coin), 64'b010);
        check("t4_rej", 64'(coin_reject), 64'd1);
        check("t4_total", 64'(current_total), 64'd0);
        tick();
        check("t4_rej_pulse", 64'(coin_reject), 64'd0);
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_ret_end", 64'(return_coin), 64'd0);

        // Overflow boundary: total at max is accepted, anything more is refused.
        coin_value = {31'h7FFF_FFFF, 31'd500, 31'd100};
        input_coin = 3'b100; tick(); clear_inputs();
        check("ovf_total_max", 64'(current_total), 64'h7FFF_FFFF);
        check("ovf_max_rej", 64'(coin_reject), 64'd0);
        input_coin = 3'b001; tick(); clear_inputs();
        check("ovf_rej", 64'(coin_reject), 64'd1);
        check("ovf_total_kept", 64'(current_total), 64'h7FFF_FFFF);
        trigger_return = 1'b1; tick(); clear_inputs();
        drain("ovf_ret", 1);
        coin_value = {31'd1000, 31'd500, 31'd100};

        // IDLE ignores select/trigger; restock refuses coins and reloads stock.
        select_item = 4'b0001; trigger_return = 1'b1; tick(); clear_inputs();
        check("idle_out", 64'(output_item), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        restock = 1'b1; input_coin = 3'b001; tick(); clear_inputs();
        check("rs_rej", 64'(coin_reject), 64'd1);
        check("rs_total", 64'(current_total), 64'd0);
        check("rs_stock0", 64'(dut.stock_q[0]), 64'd8);

        // Eight purchases empty item0; net +100 credit per round.
        for (int k = 1; k <= 8; k++) begin
            input_coin = 3'b010; tick(); clear_inputs();
            select_item = 4'b0001; tick(); clear_inputs();
            check($sformatf("buy%0d_out", k), 64'(output_item), 64'b0001);
            check($sformatf("buy%0d_total", k), 64'(current_total), 64'(100 * k));
        end
        check("empty_avail", 64'(available_item), 64'b0010);
        select_item = 4'b0001; tick(); clear_inputs();
        check("empty_out", 64'(output_item), 64'd0);
        check("empty_total", 64'(current_total), 64'd800);
        check("empty_stock0", 64'(dut.stock_q[0]), 64'd0);

        // Select and return together: dispense first, then return 300.
        select_item = 4'b0010; trigger_return = 1'b1; tick(); clear_inputs();
        check("st_out", 64'(output_item), 64'b0010);
        check("st_total", 64'(current_total), 64'd300);
        check("st_busy", 64'(busy), 64'd1);
        drain("st_ret", 3);

        // Reset asserted mid-RETURN aborts change emission at once.
        input_coin = 3'b110; tick(); clear_inputs();
        trigger_return = 1'b1; tick(); clear_inputs();
        tick();
        check("mr_c1000", 64'(return_coin), 64'b100);
        check("mr_rem", 64'(current_total), 64'd500);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_ret", 64'(return_coin), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_total", 64'(current_total), 64'd0);
        check("mr_stock0", 64'(dut.stock_q[0]), 64'd8);
        #3;
        reset_n = 1'b1;
        tick();
        check("mr_after_ret", 64'(return_coin), 64'd0);
        tick();
        check("mr_after_ret2", 64'(return_coin), 64'd0);
        check("mr_after_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_core.md
VENDING_MACHINE_CORE -- requirements
Module: vending_machine_core

Interface
REQ-001 SHALL have parameters: NUM_COINS, default 3, number of coin denominations; NUM_ITEMS, default 4, number of items; TOTAL_BITS, default 31, width of the credit total; WAIT_CYCLES, default 100, inactivity timeout; STOCK_BITS, default 4, width of each stock counter; INIT_STOCK, default 8, stock loaded at reset and on restock.
REQ-002 SHALL have ports, one clock, asynchronous active-low reset:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_input_coin  in  NUM_COINS  coin-inserted pulses
- i_select_item  in  NUM_ITEMS  item-select pulses
- i_trigger_return  in  1  user return request
- i_restock  in  1  reload all stock counters
- i_coin_value  in  NUM_COINS*TOTAL_BITS  denominations, strictly ascending by index
- i_item_price  in  NUM_ITEMS*TOTAL_BITS  item prices
- o_available_item  out  NUM_ITEMS  item purchasable now
- o_output_item  out  NUM_ITEMS  one-hot dispense pulse
- o_return_coin  out  NUM_COINS  one-hot change pulse
- o_coin_reject  out  1  inserted coin refused
- o_current_total  out  TOTAL_BITS  registered credit
- o_busy  out  1  returning change

Function
REQ-003 SHALL implement FSM IDLE, ACCEPT, RETURN.
REQ-004 IDLE: total 0; any accepted coin -> ACCEPT; i_restock honoured only in IDLE.
REQ-005 ACCEPT: sum of all asserted coins added to total each cycle; timer reloaded to WAIT_CYCLES on any accepted coin or dispense, else decremented; timer reaching 0 or i_trigger_return -> RETURN.
REQ-006 Select rule: at most one dispense per cycle, lowest-index selected item with stock>0 and total>=price; evaluated against registered total before that cycle's coins are added.
REQ-007 Dispense: o_output_item bit pulses one cycle in the next cycle; total decreases by price; stock decrements by 1 in the same edge.
REQ-008 o_available_item[i] = state==ACCEPT and stock[i]>0 and total>=price[i]; combinational from registers.
REQ-009 Overflow: if total+coin sum exceeds 2^TOTAL_BITS-1, the whole cycle's coins are refused; o_coin_reject pulses one cycle next cycle; total unchanged.
REQ-010 Coins during RETURN or with i_restock in IDLE: coins refused, o_coin_reject pulses.
REQ-011 RETURN: each cycle emit one o_return_coin pulse for the largest denomination <= remaining total and subtract it; o_busy high throughout.
REQ-012 RETURN exit: total 0, or remainder below smallest denomination (remainder cleared to 0) -> IDLE next cycle.
REQ-013 i_select_item and i_trigger_return ignored outside ACCEPT; select and trigger together: dispense performed, then RETURN.
REQ-014 Timer width SHALL be $clog2(WAIT_CYCLES+1); stock counters saturate at 0.

Reset
REQ-015 reset_n low SHALL asynchronously force: state IDLE, total 0, timer 0, stock all INIT_STOCK, all outputs 0.
REQ-016 Reset mid-RETURN SHALL abort change emission; no further pulses after release.

Structure
REQ-017 Shared package vending_machine_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-018 Change selection SHALL be sub-module vm_change_select: combinational, input remaining total and coin values, output one-hot coin and its value.

Verification (coins 100,500,1000; prices 400,500,1000,2000; WAIT_CYCLES 10)
REQ-019 Insert 1000, select item0 -> o_output_item=0001 one cycle, total 600, stock0=7.
REQ-020 Insert 500+100 same cycle, select items1 and 0 -> only item0 dispensed, total 200.
REQ-021 Total 1600, i_trigger_return -> pulses 1000, 500, 100 on consecutive cycles, then IDLE, o_busy low.
REQ-022 Total 500, no activity 10 cycles -> RETURN, one 500 pulse.
REQ-023 Stock0 reaches 0 after 8 buys -> o_available_item[0]=0, select item0 ignored, total kept.
REQ-024 Assert reset_n low mid-RETURN -> all outputs 0 immediately, total 0, stock 8.
